// File: rtl/sys_pe_pkg.sv
// Shared defaults, beat tag type and saturation helper for the sys_pe_lanes processing element.
// SYS_PE_SAT_EN selects saturating accumulation in the lanes.
package sys_pe_pkg;

    localparam int unsigned DefWl        = 16;
    localparam int unsigned DefLanes     = 4;
    localparam int unsigned DefAccw      = 40;
    localparam int unsigned DefMulStages = 2;

    typedef struct packed {
        logic active;
        logic is_end;
    } beat_tag_t;

    // Clamp a signed value to the range of a w-bit signed number (w <= 64).
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                    input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/sys_pe_mac_lane.sv
// One feature lane: signed multiplier pipeline followed by the accumulator and its result register.
// With SYS_PE_SAT_EN defined the accumulator saturates and reports it on sat_o.
module sys_pe_mac_lane
    import sys_pe_pkg::*;
#(
    parameter int unsigned WL         = DefWl,
    parameter int unsigned ACCW       = DefAccw,
    parameter int unsigned MUL_STAGES = DefMulStages
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic signed [WL-1:0]   w_i,
    input  logic signed [WL-1:0]   f_i,
    input  beat_tag_t              tag_i,
    output logic                   done_o,
    output logic signed [ACCW-1:0] sum_o
`ifdef SYS_PE_SAT_EN
    ,
    output logic                   sat_o
`endif
);

    localparam int unsigned Last = MUL_STAGES - 1;

    logic signed [2*WL-1:0] prod_full;
    logic signed [ACCW-1:0] prod_ext;

    assign prod_full = w_i * f_i;
    assign prod_ext  = ACCW'(prod_full);

    logic signed [ACCW-1:0] pipe_q [MUL_STAGES];
    logic signed [ACCW-1:0] pipe_d [MUL_STAGES];
    beat_tag_t              tag_q  [MUL_STAGES];
    beat_tag_t              tag_d  [MUL_STAGES];

    always_comb begin
        for (int i = 0; i < int'(MUL_STAGES); i++) begin
            pipe_d[i] = pipe_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (ena) begin
            pipe_d[0] = prod_ext;
            tag_d[0]  = tag_i;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                pipe_d[i] = pipe_q[i-1];
                tag_d[i]  = tag_q[i-1];
            end
        end
    end

    logic signed [ACCW-1:0] acc_q, acc_d, res_q, res_d, base, sum;
    logic                   first_q, first_d, done_q, done_d;
    beat_tag_t              tag_last;
    logic signed [ACCW-1:0] prod_last;

    assign tag_last  = tag_q[Last];
    assign prod_last = pipe_q[Last];
    // The first beat of a vector replaces the accumulator rather than adding to it.
    assign base      = first_q ? '0 : acc_q;

`ifdef SYS_PE_SAT_EN
    logic signed [ACCW:0] sum_wide;
    logic signed [63:0]   sum_clip;
    logic                 sat_now, sat_run, sat_run_q, sat_run_d, sat_res_q, sat_res_d;

    always_comb begin
        sum_wide = (ACCW+1)'(base) + (ACCW+1)'(prod_last);
        sum_clip = sat_clip(64'(sum_wide), ACCW);
        sum      = sum_clip[ACCW-1:0];
        sat_now  = (sum_clip != 64'(sum_wide));
        sat_run  = first_q ? 1'b0 : sat_run_q;
    end
`else
    assign sum = base + prod_last;
`endif

    always_comb begin
        acc_d   = acc_q;
        res_d   = res_q;
        first_d = first_q;
        done_d  = done_q;
`ifdef SYS_PE_SAT_EN
        sat_run_d = sat_run_q;
        sat_res_d = sat_res_q;
`endif
        if (ena) begin
            done_d = 1'b0;
            if (tag_last.active) begin
                if (tag_last.is_end) begin
                    res_d   = sum;
                    acc_d   = '0;
                    first_d = 1'b1;
                    done_d  = 1'b1;
`ifdef SYS_PE_SAT_EN
                    sat_res_d = sat_run | sat_now;
                    sat_run_d = 1'b0;
`endif
                end else begin
                    acc_d   = sum;
                    first_d = 1'b0;
`ifdef SYS_PE_SAT_EN
                    sat_run_d = sat_run | sat_now;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                pipe_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            acc_q   <= '0;
            res_q   <= '0;
            first_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SYS_PE_SAT_EN
            sat_run_q <= 1'b0;
            sat_res_q <= 1'b0;
`endif
        end else begin
            pipe_q  <= pipe_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            first_q <= first_d;
            done_q  <= done_d;
`ifdef SYS_PE_SAT_EN
            sat_run_q <= sat_run_d;
            sat_res_q <= sat_res_d;
`endif
        end
    end

    assign done_o = done_q;
    assign sum_o  = res_q;
`ifdef SYS_PE_SAT_EN
    assign sat_o  = sat_res_q;
`endif

endmodule

// File: rtl/sys_pe_lanes.sv
// Systolic PE: one weight stream times LANES feature lanes, registered stream forwarding and a
// depth-1 result register. SYS_PE_SAT_EN enables saturating lanes and the sat_flag output.
module sys_pe_lanes
    import sys_pe_pkg::*;
#(
    parameter int unsigned WL         = DefWl,
    parameter int unsigned LANES      = DefLanes,
    parameter int unsigned ACCW       = DefAccw,
    parameter int unsigned MUL_STAGES = DefMulStages
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [WL-1:0]         w_value,
    input  logic                  w_valid,
    input  logic                  w_end,
    input  logic [LANES*WL-1:0]   f_value,
    input  logic                  f_valid,
    input  logic                  f_end,
    output logic [WL-1:0]         w_out_value,
    output logic                  w_out_valid,
    output logic                  w_out_end,
    output logic [LANES*WL-1:0]   f_out_value,
    output logic                  f_out_valid,
    output logic                  f_out_end,
    output logic [LANES*ACCW-1:0] res_value,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  err_flag,
`ifdef SYS_PE_SAT_EN
    output logic                  sat_flag,
`endif
    output logic                  ovf_flag
);

    // The capture stage doubles as the forwarding register: both have identical timing.
    logic [WL-1:0]       w_val_q, w_val_d;
    logic [LANES*WL-1:0] f_val_q, f_val_d;
    logic                w_vld_q, w_vld_d, w_end_q, w_end_d;
    logic                f_vld_q, f_vld_d, f_end_q, f_end_d;

    always_comb begin
        w_val_d = w_val_q;
        w_vld_d = w_vld_q;
        w_end_d = w_end_q;
        f_val_d = f_val_q;
        f_vld_d = f_vld_q;
        f_end_d = f_end_q;
        if (ena) begin
            w_val_d = w_value;
            w_vld_d = w_valid;
            w_end_d = w_end;
            f_val_d = f_value;
            f_vld_d = f_valid;
            f_end_d = f_end;
        end
    end

    beat_tag_t s0_tag;
    logic      misalign;

    always_comb begin
        s0_tag.active = w_vld_q & f_vld_q;
        s0_tag.is_end = s0_tag.active & (w_end_q | f_end_q);
        misalign      = (w_vld_q ^ f_vld_q) | (s0_tag.active & (w_end_q ^ f_end_q));
    end

    logic [LANES-1:0]      lane_done;
    logic [LANES*ACCW-1:0] lane_sum;
`ifdef SYS_PE_SAT_EN
    logic [LANES-1:0]      lane_sat;
`endif

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        sys_pe_mac_lane #(
            .WL        (WL),
            .ACCW      (ACCW),
            .MUL_STAGES(MUL_STAGES)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (ena),
            .w_i   (w_val_q),
            .f_i   (f_val_q[i*WL +: WL]),
            .tag_i (s0_tag),
            .done_o(lane_done[i]),
`ifdef SYS_PE_SAT_EN
            .sat_o (lane_sat[i]),
`endif
            .sum_o (lane_sum[i*ACCW +: ACCW])
        );
    end

    logic                  new_res;
    logic                  res_vld_q, res_vld_d, err_q, err_d, ovf_q, ovf_d, sat_q, sat_d;
    logic [LANES*ACCW-1:0] res_val_q, res_val_d;

    // Lanes share tags, so their done strobes are always identical.
    assign new_res = ena & (&lane_done);

    always_comb begin
        res_vld_d = res_vld_q;
        res_val_d = res_val_q;
        ovf_d     = ovf_q;
        sat_d     = sat_q;
        err_d     = err_q | (ena & misalign);
        if (res_vld_q && res_ready) begin
            res_vld_d = 1'b0;
        end
        if (new_res) begin
            if (res_vld_q && !res_ready) begin
                ovf_d = 1'b1;
            end else begin
                res_vld_d = 1'b1;
                res_val_d = lane_sum;
`ifdef SYS_PE_SAT_EN
                sat_d     = |lane_sat;
`else
                sat_d     = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_val_q   <= '0;
            w_vld_q   <= 1'b0;
            w_end_q   <= 1'b0;
            f_val_q   <= '0;
            f_vld_q   <= 1'b0;
            f_end_q   <= 1'b0;
            res_vld_q <= 1'b0;
            res_val_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            w_val_q   <= w_val_d;
            w_vld_q   <= w_vld_d;
            w_end_q   <= w_end_d;
            f_val_q   <= f_val_d;
            f_vld_q   <= f_vld_d;
            f_end_q   <= f_end_d;
            res_vld_q <= res_vld_d;
            res_val_q <= res_val_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

    assign w_out_value = w_val_q;
    assign w_out_valid = w_vld_q;
    assign w_out_end   = w_end_q;
    assign f_out_value = f_val_q;
    assign f_out_valid = f_vld_q;
    assign f_out_end   = f_end_q;
    assign res_value   = res_val_q;
    assign res_valid   = res_vld_q;
    assign err_flag    = err_q;
    assign ovf_flag    = ovf_q;
`ifdef SYS_PE_SAT_EN
    assign sat_flag    = sat_q & res_vld_q;
`endif

endmodule

// File: tb/tb_sys_pe_lanes.sv
// Scoreboard bench for sys_pe_lanes (WL=8, ACCW=20, LANES=2, MUL_STAGES=2); honours SYS_PE_SAT_EN.
module tb_sys_pe_lanes;

    localparam int WL    = 8;
    localparam int LANES = 2;
    localparam int ACCW  = 20;
    localparam int MS    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n, ena, res_ready;
    logic [WL-1:0]         w_value;
    logic                  w_valid, w_end, f_valid, f_end;
    logic [LANES*WL-1:0]   f_value;
    logic [WL-1:0]         w_out_value;
    logic                  w_out_valid, w_out_end, f_out_valid, f_out_end;
    logic [LANES*WL-1:0]   f_out_value;
    logic [LANES*ACCW-1:0] res_value;
    logic                  res_valid, err_flag, ovf_flag;
`ifdef SYS_PE_SAT_EN
    logic                  sat_flag;
`endif

    sys_pe_lanes #(
        .WL        (WL),
        .LANES     (LANES),
        .ACCW      (ACCW),
        .MUL_STAGES(MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .w_value    (w_value),
        .w_valid    (w_valid),
        .w_end      (w_end),
        .f_value    (f_value),
        .f_valid    (f_valid),
        .f_end      (f_end),
        .w_out_value(w_out_value),
        .w_out_valid(w_out_valid),
        .w_out_end  (w_out_end),
        .f_out_value(f_out_value),
        .f_out_valid(f_out_valid),
        .f_out_end  (f_out_end),
        .res_value  (res_value),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .err_flag   (err_flag),
`ifdef SYS_PE_SAT_EN
        .sat_flag   (sat_flag),
`endif
        .ovf_flag   (ovf_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [ACCW-1:0] l0;
        logic signed [ACCW-1:0] l1;
        logic                   sat;
        int                     rise;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint lane(input int i);
        logic signed [ACCW-1:0] s;
        s = res_value[i*ACCW +: ACCW];
        return longint'(s);
    endfunction

    task automatic push(input int e0, input int e1, input logic sat, input int rise);
        exp_t e;
        e.l0   = ACCW'(e0);
        e.l1   = ACCW'(e1);
        e.sat  = sat;
        e.rise = rise;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per accepted result.
    int   rise_cyc = -1;
    logic prev_vld = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
            end else begin
                if (res_valid && !prev_vld) rise_cyc = cyc;
                prev_vld = res_valid;
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_lane0", lane(0), longint'(e.l0));
                        chk("res_lane1", lane(1), longint'(e.l1));
                        chk("res_latency", rise_cyc, e.rise);
`ifdef SYS_PE_SAT_EN
                        chk("sat_flag", sat_flag, e.sat);
`endif
                    end
                end
            end
        end
    end

    task automatic beat(input bit wv, input bit fv, input bit we, input bit fe,
                        input int w, input int f0, input int f1);
        w_valid = wv;
        f_valid = fv;
        w_end   = we;
        f_end   = fe;
        w_value = WL'(w);
        f_value = {WL'(f1), WL'(f0)};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        w_valid = 1'b0;
        f_valid = 1'b0;
        w_end   = 1'b0;
        f_end   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_value"}, res_value, 0);
        chk({tag, "_w_out_valid"}, w_out_valid, 0);
        chk({tag, "_w_out_value"}, w_out_value, 0);
        chk({tag, "_f_out_valid"}, f_out_valid, 0);
        chk({tag, "_err_flag"}, err_flag, 0);
        chk({tag, "_ovf_flag"}, ovf_flag, 0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 reset_checks(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int                     rise;
        longint                 m;
        logic                   s6;
        logic signed [ACCW-1:0] e6;

        rst_n = 1'b1; ena = 1'b1; res_ready = 1'b1;
        w_value = '0; f_value = '0;
        w_valid = 1'b0; f_valid = 1'b0; w_end = 1'b0; f_end = 1'b0;
        #2 rst_n = 1'b0;
        #2 reset_checks("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-beat vector, pass-through and one-cycle result pulse.
        beat(1, 1, 0, 0, 1, 4, -1);
        chk("pt_w_value", w_out_value, 1);
        chk("pt_w_valid", w_out_valid, 1);
        chk("pt_f_value", f_out_value, 16'hFF04);
        chk("pt_f_end", f_out_end, 0);
        beat(1, 1, 0, 0, 2, 5, -1);
        rise = cyc + 5;
        push(32, -6, 1'b0, rise);
        beat(1, 1, 1, 1, 3, 6, -1);
        chk("pt_w_end", w_out_end, 1);
        idle(4);
        chk("t1_valid_hi", res_valid, 1);
        idle(1);
        chk("t1_valid_lo", res_valid, 0);
        idle(2);

        // Same vector with a three-cycle stall mid-vector.
        beat(1, 1, 0, 0, 1, 4, -1);
        beat(1, 1, 0, 0, 2, 5, -1);
        ena = 1'b0;
        beat(1, 1, 1, 1, 99, 99, 99);
        beat(1, 1, 1, 1, 99, 99, 99);
        beat(1, 1, 1, 1, 99, 99, 99);
        chk("stall_w_value", w_out_value, 2);
        chk("stall_f_value", f_out_value, 16'hFF05);
        chk("stall_w_end", w_out_end, 0);
        ena = 1'b1;
        rise = cyc + 5;
        push(32, -6, 1'b0, rise);
        beat(1, 1, 1, 1, 3, 6, -1);
        idle(8);

        // Back-to-back results with the output blocked; the second one is dropped.
        res_ready = 1'b0;
        rise = cyc + 5;
        push(6, 6, 1'b0, rise);
        beat(1, 1, 1, 1, 2, 3, 3);
        beat(1, 1, 1, 1, 5, 5, 5);
        idle(8);
        chk("hold_valid", res_valid, 1);
        chk("hold_lane0", lane(0), 6);
        chk("hold_lane1", lane(1), 6);
        chk("ovf_set", ovf_flag, 1);
        res_ready = 1'b1;
        idle(1);
        chk("hold_cleared", res_valid, 0);

        // Reset in the middle of a vector discards the partial sum.
        beat(1, 1, 0, 0, 1, 1, 1);
        beat(1, 1, 0, 0, 1, 1, 1);
        idle(1);
        pulse_reset("rst_mid");
        rise = cyc + 5;
        push(49, 49, 1'b0, rise);
        beat(1, 1, 1, 1, 7, 7, 7);
        idle(8);

        // End misalignment on an active beat: error, still treated as an end.
        rise = cyc + 5;
        push(6, 8, 1'b0, rise);
        beat(1, 1, 1, 0, 2, 3, 4);
        idle(1);
        chk("err_end_mis", err_flag, 1);
        idle(6);
        pulse_reset("rst_err");

        // Weight-only beat is ignored but flagged.
        beat(1, 0, 1, 1, 9, 9, 9);
        rise = cyc + 5;
        push(1, 2, 1'b0, rise);
        beat(1, 1, 1, 1, 1, 1, 2);
        idle(1);
        chk("err_valid_mis", err_flag, 1);
        idle(6);

        // Long vector that overflows the accumulator range.
        m  = 0;
        s6 = 1'b0;
`ifdef SYS_PE_SAT_EN
        for (int k = 0; k < 70; k++) begin
            m = m + 127 * 127;
            if (m > 524287) begin
                m  = 524287;
                s6 = 1'b1;
            end
        end
        e6 = ACCW'(m);
`else
        e6 = '0;
        for (int k = 0; k < 70; k++) e6 = e6 + 20'sd16129;
`endif
        for (int k = 0; k < 69; k++) beat(1, 1, 0, 0, 127, 127, 127);
        rise = cyc + 5;
        push(int'(e6), int'(e6), s6, rise);
        beat(1, 1, 1, 1, 127, 127, 127);
        idle(8);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
